fb_swap_ctrl: RTL and testbench



---
 rtl/fb_swap_ctrl.sv | 97 +++++++++
 tb/tb_fb_swap_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_swap_ctrl.sv
// Double-buffer swap controller: hands the finished frame to the display,
// waits for the swap/swapped handshake, then flips the render target.
module fb_swap_ctrl #(
  parameter logic [31:0] FB_ADDR_0      = 32'h01E00000,
  parameter logic [31:0] FB_ADDR_1      = 32'h01F2C000,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic        aclk,
  input  logic        resetn,
  input  logic        commit_valid,
  output logic        commit_ready,
  output logic [31:0] renderAddr,
  output logic        renderEnable,
  output logic        swap,
  output logic [31:0] fbAddr,
  input  logic        swapped,
  output logic [15:0] frameCount,
  output logic        swapError
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, REL} state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] timer_reg;
  logic [31:0]      prev_addr_reg;
  logic             timer_done;
  logic [31:0]      flipped_addr;

  assign timer_done   = (timer_reg == CNT_LAST);
  assign flipped_addr = (renderAddr == FB_ADDR_0) ? FB_ADDR_1 : FB_ADDR_0;
  assign commit_ready = (state_reg == IDLE) && swapped;

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      timer_reg     <= '0;
      prev_addr_reg <= FB_ADDR_0;
      swap          <= 1'b0;
      fbAddr        <= FB_ADDR_0;
      renderAddr    <= FB_ADDR_1;
      renderEnable  <= 1'b1;
      frameCount    <= 16'd0;
      swapError     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (commit_valid && commit_ready) begin
            fbAddr       <= renderAddr;
            swap         <= 1'b1;
            renderEnable <= 1'b0;
            timer_reg    <= '0;
            state_reg    <= REQ;
          end
        end
        REQ: begin
          if (!swapped) begin
            // Display has latched fbAddr; it is now the displayed buffer.
            swap          <= 1'b0;
            prev_addr_reg <= fbAddr;
            timer_reg     <= '0;
            state_reg     <= REL;
          end else if (timer_done) begin
            swap         <= 1'b0;
            swapError    <= 1'b1;
            renderEnable <= 1'b1;
            fbAddr       <= prev_addr_reg;
            timer_reg    <= '0;
            state_reg    <= IDLE;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        REL: begin
          // A stuck release still completes the flip: the display already owns the new buffer.
          if (swapped || timer_done) begin
            if (!swapped) swapError <= 1'b1;
            renderAddr   <= flipped_addr;
            frameCount   <= frameCount + 16'd1;
            renderEnable <= 1'b1;
            timer_reg    <= '0;
            state_reg    <= IDLE;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        default: begin
          timer_reg <= '0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// Bench for fb_swap_ctrl: cycle table for single swaps, scoreboard of swap
// addresses, and hand sequences for hold-off, timeouts, async reset and wrap.
module tb_fb_swap_ctrl;

  localparam logic [31:0] F0 = 32'h01E00000;
  localparam logic [31:0] F1 = 32'h01F2C000;
  localparam logic [1:0] M_NORMAL = 2'd0;
  localparam logic [1:0] M_HOLD   = 2'd1;
  localparam logic [1:0] M_STUCK  = 2'd2;

  logic        aclk;
  logic        resetn;
  logic        commit_valid;
  logic        commit_ready;
  logic [31:0] renderAddr;
  logic        renderEnable;
  logic        swap;
  logic [31:0] fbAddr;
  logic        swapped;
  logic [15:0] frameCount;
  logic        swapError;

  logic [1:0]  mode;
  logic        swap_q;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        cv;
    logic        e_swap;
    logic        e_re;
    logic        e_cr;
    logic [31:0] e_ra;
    logic [31:0] e_fa;
    logic [15:0] e_fc;
  } vec_t;

  vec_t vecs[10];

  fb_swap_ctrl #(
    .FB_ADDR_0(F0),
    .FB_ADDR_1(F1),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .aclk(aclk),
    .resetn(resetn),
    .commit_valid(commit_valid),
    .commit_ready(commit_ready),
    .renderAddr(renderAddr),
    .renderEnable(renderEnable),
    .swap(swap),
    .fbAddr(fbAddr),
    .swapped(swapped),
    .frameCount(frameCount),
    .swapError(swapError)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  // Display model: drops swapped the cycle after seeing swap, raises it one cycle later.
  always @(posedge aclk or negedge resetn) begin
    if (!resetn) swapped <= 1'b1;
    else begin
      case (mode)
        M_HOLD:  swapped <= 1'b0;
        M_STUCK: swapped <= 1'b1;
        default: swapped <= !(swap && swapped);
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every rising swap must present the next expected buffer address.
  always @(negedge aclk) begin
    if (!resetn) swap_q <= 1'b0;
    else begin
      if (swap && !swap_q) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_swap actual=%0h expected=none (cycle %0d)", fbAddr, cyc);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          $display("swap cycle=%0d fbAddr=%0h expected=%0h", cyc, fbAddr, e);
          check("swap_fbAddr", fbAddr, e);
        end
      end
      swap_q <= swap;
    end
  end

  task automatic do_reset();
    resetn = 1'b0;
    commit_valid = 1'b0;
    mode = M_NORMAL;
    exp_q.delete();
    repeat (3) @(posedge aclk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic wait_accept(output int at);
    bit ok;
    ok = 1'b0;
    at = -1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge aclk);
      if (commit_valid && commit_ready) begin
        ok = 1'b1;
        at = cyc;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL accept_timeout actual=no_accept expected=accept (cycle %0d)", cyc);
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic one_swap();
    int at;
    commit_valid = 1'b1;
    wait_accept(at);
    commit_valid = 1'b0;
    settle(6);
  endtask

  initial begin
    int at;
    int prev_at;
    int n;

    vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b1, F1, F0, 16'd0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, F1, F1, 16'd0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, F1, F1, 16'd0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, F1, F1, 16'd0};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, F0, F1, 16'd1};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b1, F0, F1, 16'd1};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, F0, F0, 16'd1};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, F0, F0, 16'd1};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, F0, F0, 16'd1};
    vecs[9] = '{1'b0, 1'b0, 1'b1, 1'b1, F1, F0, 16'd2};

    // Reset values.
    do_reset();
    @(negedge aclk);
    check("rst_swap", swap, 0);
    check("rst_fbAddr", fbAddr, F0);
    check("rst_renderAddr", renderAddr, F1);
    check("rst_renderEnable", renderEnable, 1);
    check("rst_frameCount", frameCount, 0);
    check("rst_swapError", swapError, 0);
    check("rst_commit_ready", commit_ready, 1);
    @(posedge aclk);
    #1;

    // Cycle-accurate table: two single commits with a 1-cycle display.
    exp_q.push_back(F1);
    exp_q.push_back(F0);
    for (int i = 0; i < 10; i++) begin
      commit_valid = vecs[i].cv;
      @(negedge aclk);
      check($sformatf("v%0d_swap", i), swap, vecs[i].e_swap);
      check($sformatf("v%0d_renderEnable", i), renderEnable, vecs[i].e_re);
      check($sformatf("v%0d_commit_ready", i), commit_ready, vecs[i].e_cr);
      check($sformatf("v%0d_renderAddr", i), renderAddr, vecs[i].e_ra);
      check($sformatf("v%0d_fbAddr", i), fbAddr, vecs[i].e_fa);
      check($sformatf("v%0d_frameCount", i), frameCount, vecs[i].e_fc);
      @(posedge aclk);
      #1;
    end
    commit_valid = 1'b0;
    check("table_swapError", swapError, 0);

    // Four back-to-back commits with commit_valid held high.
    do_reset();
    exp_q.push_back(F1);
    exp_q.push_back(F0);
    exp_q.push_back(F1);
    exp_q.push_back(F0);
    commit_valid = 1'b1;
    prev_at = -1;
    for (int k = 0; k < 4; k++) begin
      wait_accept(at);
      if (k > 0) check($sformatf("b2b_spacing%0d", k), at - prev_at, 4);
      prev_at = at;
    end
    commit_valid = 1'b0;
    settle(6);
    check("b2b_frameCount", frameCount, 4);
    check("b2b_swapError", swapError, 0);
    check("b2b_renderAddr", renderAddr, F1);

    // Display holds swapped low: commit must wait, then go on the release cycle.
    do_reset();
    mode = M_HOLD;
    settle(2);
    commit_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      check("hold_commit_ready", commit_ready, 0);
      check("hold_swap", swap, 0);
    end
    @(posedge aclk);
    #1;
    exp_q.push_back(F1);
    mode = M_NORMAL;
    prev_at = cyc;
    wait_accept(at);
    commit_valid = 1'b0;
    check("hold_accept_cycle", at - prev_at, 1);
    settle(6);
    check("hold_frameCount", frameCount, 1);

    // REQ timeout: display never drops swapped.
    do_reset();
    mode = M_STUCK;
    exp_q.push_back(F1);
    commit_valid = 1'b1;
    wait_accept(at);
    commit_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge aclk);
      if (!swap) break;
      n++;
    end
    check("req_timeout_cycles", n, 16);
    check("req_to_swapError", swapError, 1);
    check("req_to_renderAddr", renderAddr, F1);
    check("req_to_fbAddr", fbAddr, F0);
    check("req_to_frameCount", frameCount, 0);
    check("req_to_renderEnable", renderEnable, 1);
    check("req_to_commit_ready", commit_ready, 1);
    @(posedge aclk);
    #1;
    mode = M_NORMAL;
    exp_q.push_back(F1);
    one_swap();
    check("recommit_frameCount", frameCount, 1);
    check("recommit_renderAddr", renderAddr, F0);
    check("recommit_swapError_sticky", swapError, 1);

    // REL timeout: display latches but never releases.
    do_reset();
    exp_q.push_back(F1);
    commit_valid = 1'b1;
    wait_accept(at);
    commit_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      if (!swapped) break;
    end
    mode = M_HOLD;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge aclk);
      if (renderEnable) break;
      n++;
    end
    check("rel_timeout_cycles", n, 16);
    check("rel_to_swapError", swapError, 1);
    check("rel_to_renderAddr", renderAddr, F0);
    check("rel_to_frameCount", frameCount, 1);
    check("rel_to_fbAddr", fbAddr, F1);
    check("rel_to_swap", swap, 0);
    @(posedge aclk);
    #1;
    mode = M_NORMAL;

    // Asynchronous reset while in REL.
    do_reset();
    exp_q.push_back(F1);
    commit_valid = 1'b1;
    wait_accept(at);
    commit_valid = 1'b0;
    repeat (3) @(negedge aclk);
    check("arst_in_rel", {29'd0, swap, renderEnable, commit_ready}, 0);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_swap", swap, 0);
    check("arst_renderEnable", renderEnable, 1);
    check("arst_fbAddr", fbAddr, F0);
    check("arst_renderAddr", renderAddr, F1);
    check("arst_commit_ready", commit_ready, 1);
    repeat (2) @(posedge aclk);
    #1;
    resetn = 1'b1;
    settle(1);
    exp_q.push_back(F1);
    one_swap();
    check("arst_after_frameCount", frameCount, 1);
    check("arst_after_renderAddr", renderAddr, F0);
    check("arst_after_swapError", swapError, 0);

    // frameCount wrap from 16'hFFFF.
    do_reset();
    force dut.frameCount = 16'hFFFF;
    @(posedge aclk);
    #1;
    release dut.frameCount;
    @(negedge aclk);
    check("wrap_preload", frameCount, 16'hFFFF);
    @(posedge aclk);
    #1;
    exp_q.push_back(F1);
    one_swap();
    check("wrap_frameCount", frameCount, 0);
    check("wrap_swapError", swapError, 0);
    check("wrap_renderAddr", renderAddr, F0);
    check("wrap_renderEnable", renderEnable, 1);
    check("wrap_fbAddr", fbAddr, F1);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
